fetch_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 8-bit core. Drives the program counter's

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller for the 8-bit core: owns PC sequencing, handshakes
// program-memory byte reads, latches opcode/operand and issues one-cycle execute strobes.
module fetch_sequencer #(
    parameter int          TIMEOUT  = 16,
    parameter logic [3:0]  HALT_OPC = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr_in,
    input  logic       mem_ready,
    input  logic       zero_flag,
    output logic       mem_rd,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [7:0] pc_target,
    output logic [3:0] opcode,
    output logic [7:0] operand,
    output logic       alu_en,
    output logic       reg_we,
    output logic       busy,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_ALU = 4'h1;
    localparam logic [3:0] OPC_LDI = 4'h2;
    localparam logic [3:0] OPC_JMP = 4'h3;
    localparam logic [3:0] OPC_JZ  = 4'h4;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] opcode_reg;
    logic [7:0] operand_reg;
    logic [7:0] wait_cnt_reg;
    logic       mem_rd_reg;
    logic       alu_en_reg;
    logic       reg_we_reg;
    logic       busy_reg;
    logic       halted_reg;
    logic       fault_reg;
    logic       fault_set;
    logic       timed_out;
    logic       waiting_state;

    assign waiting_state = (state_reg == S_FETCH) || (state_reg == S_OPERAND);

    // The current cycle is the TIMEOUT-th consecutive cycle without mem_ready.
    assign timed_out = (TIMEOUT != 0) && !mem_ready && (wait_cnt_reg == 8'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        fault_set  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH, S_OPERAND: begin
                if (mem_ready) begin
                    state_next = (state_reg == S_FETCH) ? S_DECODE : S_EXEC;
                end else if (timed_out) begin
                    state_next = S_HALT;
                    fault_set  = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode_reg == HALT_OPC) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode_reg)
                        OPC_NOP:                  state_next = S_FETCH;
                        OPC_ALU:                  state_next = S_EXEC;
                        OPC_LDI, OPC_JMP, OPC_JZ: state_next = S_OPERAND;
                        default: begin
                            state_next = S_HALT;
                            fault_set  = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC:  state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Byte-accept strobes and the JZ decision follow the inputs within the cycle.
    assign ir_load = (state_reg == S_FETCH) && mem_ready;
    assign pc_inc  = waiting_state && mem_ready;
    assign pc_load = (state_reg == S_EXEC) &&
                     ((opcode_reg == OPC_JMP) || ((opcode_reg == OPC_JZ) && zero_flag));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            opcode_reg   <= 4'h0;
            operand_reg  <= 8'h00;
            wait_cnt_reg <= 8'h00;
            mem_rd_reg   <= 1'b0;
            alu_en_reg   <= 1'b0;
            reg_we_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            halted_reg   <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_FETCH) && mem_ready) opcode_reg <= instr_in[7:4];
            if ((state_reg == S_OPERAND) && mem_ready) operand_reg <= instr_in;

            // Restart the wait count on every entry into a read state; saturate at 0xFF.
            if (((state_next == S_FETCH) || (state_next == S_OPERAND)) && (state_next != state_reg)) begin
                wait_cnt_reg <= 8'h00;
            end else if (waiting_state && !mem_ready && (wait_cnt_reg != 8'hFF)) begin
                wait_cnt_reg <= wait_cnt_reg + 8'h01;
            end

            mem_rd_reg <= (state_next == S_FETCH) || (state_next == S_OPERAND);
            alu_en_reg <= (state_next == S_EXEC) && (opcode_reg == OPC_ALU);
            reg_we_reg <= (state_next == S_EXEC) && (opcode_reg == OPC_LDI);
            busy_reg   <= (state_next != S_IDLE) && (state_next != S_HALT);
            halted_reg <= (state_next == S_HALT);
            fault_reg  <= fault_reg | fault_set;
        end
    end

    assign mem_rd    = mem_rd_reg;
    assign alu_en    = alu_en_reg;
    assign reg_we    = reg_we_reg;
    assign busy      = busy_reg;
    assign halted    = halted_reg;
    assign fault     = fault_reg;
    assign opcode    = opcode_reg;
    assign operand   = operand_reg;
    assign pc_target = operand_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle stimulus with hand-computed expectations,
// checked on the falling edge.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] instr_in = 8'h00;
    logic       mem_ready = 1'b0;
    logic       zero_flag = 1'b0;
    logic       mem_rd, ir_load, pc_inc, pc_load, alu_en, reg_we, busy, halted, fault;
    logic [7:0] pc_target, operand;
    logic [3:0] opcode;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    fetch_sequencer #(.TIMEOUT(16), .HALT_OPC(4'hF)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .instr_in  (instr_in),
        .mem_ready (mem_ready),
        .zero_flag (zero_flag),
        .mem_rd    (mem_rd),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .opcode    (opcode),
        .operand   (operand),
        .alu_en    (alu_en),
        .reg_we    (reg_we),
        .busy      (busy),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample at the falling edge.
    task automatic apply(input logic s, input logic [7:0] ins, input logic r, input logic z);
        @(posedge clk);
        #1;
        start     = s;
        instr_in  = ins;
        mem_ready = r;
        zero_flag = z;
        @(negedge clk);
        cyc_n++;
        $display("cyc %0d start=%b instr=%02h rdy=%b zf=%b | rd=%b ir=%b inc=%b ld=%b tgt=%02h opc=%h opr=%02h alu=%b we=%b busy=%b halt=%b fault=%b",
                 cyc_n, s, ins, r, z, mem_rd, ir_load, pc_inc, pc_load, pc_target, opcode,
                 operand, alu_en, reg_we, busy, halted, fault);
        check("inc_load_exclusive", {31'd0, pc_inc & pc_load}, 32'd0);
    endtask

    // Asserted away from any clock edge so the zero check proves the reset is asynchronous.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_outputs_zero",
              {3'd0, mem_rd, ir_load, pc_inc, pc_load, alu_en, reg_we, busy, halted, fault,
               opcode, operand, pc_target}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        #3;
        do_reset();

        // 1: NOP, NOP, HALT
        apply(1, 8'h00, 1, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_mem_rd", mem_rd, 0);
        apply(0, 8'h00, 1, 0);
        check("t1_c1_pc_inc", pc_inc, 1);
        check("t1_c1_ir_load", ir_load, 1);
        check("t1_c1_mem_rd", mem_rd, 1);
        check("t1_c1_busy", busy, 1);
        apply(0, 8'h00, 1, 0);
        check("t1_c2_pc_inc", pc_inc, 0);
        check("t1_c2_mem_rd", mem_rd, 0);
        apply(0, 8'h00, 1, 0);
        check("t1_c3_pc_inc", pc_inc, 1);
        apply(0, 8'h00, 1, 0);
        check("t1_c4_pc_inc", pc_inc, 0);
        apply(0, 8'hF0, 1, 0);
        check("t1_c5_pc_inc", pc_inc, 1);
        apply(0, 8'hF0, 1, 0);
        check("t1_c6_opcode", opcode, 4'hF);
        check("t1_c6_halted", halted, 0);
        apply(1, 8'hF0, 1, 0);
        check("t1_halted", halted, 1);
        check("t1_fault", fault, 0);
        check("t1_busy", busy, 0);
        check("t1_halt_pc_inc", pc_inc, 0);
        check("t1_halt_mem_rd", mem_rd, 0);
        apply(1, 8'hF0, 1, 0);
        check("t1_halt_stays", halted, 1);

        // 2/3: JMP 3C, JZ 10 not taken, JZ 10 taken, ALU, LDI AA, slow fetch of HALT
        do_reset();
        apply(1, 8'h00, 0, 0);
        apply(0, 8'h30, 1, 0);
        check("t2_fetch_pc_inc", pc_inc, 1);
        apply(0, 8'h30, 1, 0);
        check("t2_decode_opcode", opcode, 4'h3);
        apply(0, 8'h3C, 1, 0);
        check("t2_operand_pc_inc", pc_inc, 1);
        check("t2_operand_ir_load", ir_load, 0);
        check("t2_operand_mem_rd", mem_rd, 1);
        apply(0, 8'h3C, 1, 0);
        check("t2_exec_pc_load", pc_load, 1);
        check("t2_exec_pc_target", pc_target, 8'h3C);
        check("t2_exec_pc_inc", pc_inc, 0);
        check("t2_exec_alu_en", alu_en, 0);
        apply(0, 8'h40, 1, 0);
        check("t2_refetch_mem_rd", mem_rd, 1);
        check("t2_refetch_pc_load", pc_load, 0);
        check("t2_refetch_pc_inc", pc_inc, 1);
        apply(0, 8'h40, 1, 0);
        apply(0, 8'h10, 1, 0);
        apply(0, 8'h10, 1, 0);
        check("t3_jz_zf0_pc_load", pc_load, 0);
        check("t3_jz_zf0_target", pc_target, 8'h10);
        apply(0, 8'h40, 1, 0);
        apply(0, 8'h40, 1, 0);
        apply(0, 8'h10, 1, 0);
        apply(0, 8'h10, 1, 1);
        check("t3_jz_zf1_pc_load", pc_load, 1);
        check("t3_jz_zf1_target", pc_target, 8'h10);
        apply(0, 8'h10, 1, 0);
        check("alu_fetch_ir_load", ir_load, 1);
        apply(0, 8'h10, 1, 0);
        check("alu_decode_opcode", opcode, 4'h1);
        apply(0, 8'h10, 1, 0);
        check("alu_exec_alu_en", alu_en, 1);
        check("alu_exec_reg_we", reg_we, 0);
        check("alu_exec_pc_load", pc_load, 0);
        apply(0, 8'h25, 1, 0);
        apply(0, 8'h25, 1, 0);
        apply(0, 8'hAA, 1, 0);
        apply(0, 8'hAA, 1, 0);
        check("ldi_exec_reg_we", reg_we, 1);
        check("ldi_exec_alu_en", alu_en, 0);
        check("ldi_exec_operand", operand, 8'hAA);
        check("ldi_exec_pc_load", pc_load, 0);
        for (int i = 0; i < 15; i++) apply(0, 8'hF0, 0, 0);
        check("t4_wait15_pc_inc", pc_inc, 0);
        check("t4_wait15_mem_rd", mem_rd, 1);
        check("t4_wait15_halted", halted, 0);
        apply(0, 8'hF0, 1, 0);
        check("t4_late_ir_load", ir_load, 1);
        check("t4_late_pc_inc", pc_inc, 1);
        check("t4_late_fault", fault, 0);
        apply(0, 8'hF0, 1, 0);
        apply(0, 8'hF0, 1, 0);
        check("t4_late_halted", halted, 1);
        check("t4_late_no_fault", fault, 0);

        // 4: fetch times out after 16 waiting cycles
        do_reset();
        apply(1, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            apply(0, 8'h00, 0, 0);
            check("t4_wait_pc_inc", pc_inc, 0);
        end
        apply(0, 8'h00, 1, 0);
        check("t4_timeout_halted", halted, 1);
        check("t4_timeout_fault", fault, 1);
        check("t4_timeout_pc_inc", pc_inc, 0);
        check("t4_timeout_ir_load", ir_load, 0);
        check("t4_timeout_mem_rd", mem_rd, 0);

        // 5: illegal opcode 0x7
        do_reset();
        check("t5_fault_cleared", fault, 0);
        apply(1, 8'h00, 1, 0);
        apply(0, 8'h70, 1, 0);
        apply(0, 8'h70, 1, 0);
        apply(1, 8'h00, 1, 0);
        check("t5_halted", halted, 1);
        check("t5_fault", fault, 1);
        apply(1, 8'h00, 1, 0);
        apply(0, 8'h00, 1, 0);
        apply(1, 8'h00, 1, 0);
        check("t5_start_ignored_halted", halted, 1);
        check("t5_start_ignored_busy", busy, 0);
        check("t5_start_ignored_mem_rd", mem_rd, 0);

        // 6: reset during an operand wait, then restart
        do_reset();
        apply(1, 8'h00, 0, 0);
        apply(0, 8'h20, 1, 0);
        apply(0, 8'h20, 1, 0);
        apply(0, 8'h00, 0, 0);
        check("t6_operand_wait_mem_rd", mem_rd, 1);
        apply(0, 8'h00, 0, 0);
        check("t6_opcode_before_reset", opcode, 4'h2);
        mem_ready = 1'b1;
        do_reset();
        apply(1, 8'h00, 0, 0);
        apply(0, 8'h99, 1, 0);
        check("t6_restart_mem_rd", mem_rd, 1);
        check("t6_restart_opcode", opcode, 4'h0);
        check("t6_restart_operand", operand, 8'h00);
        check("t6_restart_ir_load", ir_load, 1);
        apply(0, 8'h00, 1, 0);
        check("t6_restart_latched", opcode, 4'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
